// File: rtl/apple_iie_timing_pkg.sv
// Shared constants and types for the Apple IIe master timing generator and
// the strobe decode reused by the video-stage model.
package apple_iie_timing_pkg;

    localparam int H_CYCLES_DEF     = 65;
    localparam int LONG_EXTRA_DEF   = 2;
    localparam int V_LINES_NTSC_DEF = 262;
    localparam int V_LINES_PAL_DEF  = 312;

    typedef logic [3:0] tick_t;

    localparam tick_t TICK_NORMAL_LAST = 4'd13;
    localparam tick_t TICK_LONG_LAST   = 4'd15;

    // Strobe window boundaries; the "B" windows that run to the end of the
    // cycle are closed by the cycle's last tick so they stretch in the long cycle.
    localparam tick_t PHI0_FIRST  = 4'd7;
    localparam tick_t Q3_A_FIRST  = 4'd0;
    localparam tick_t Q3_A_LAST   = 4'd3;
    localparam tick_t Q3_B_FIRST  = 4'd7;
    localparam tick_t Q3_B_LAST   = 4'd10;
    localparam tick_t RAS_A_FIRST = 4'd2;
    localparam tick_t RAS_A_LAST  = 4'd6;
    localparam tick_t RAS_B_FIRST = 4'd9;
    localparam tick_t CAS_A_FIRST = 4'd4;
    localparam tick_t CAS_A_LAST  = 4'd6;
    localparam tick_t CAS_B_FIRST = 4'd11;
    localparam tick_t AX_A_FIRST  = 4'd0;
    localparam tick_t AX_A_LAST   = 4'd2;
    localparam tick_t AX_B_FIRST  = 4'd7;
    localparam tick_t AX_B_LAST   = 4'd9;

    typedef struct packed {
        logic phi_0;
        logic q3;
        logic pras_n;
        logic pcas_n;
        logic ax;
    } strobe_t;

    localparam strobe_t STROBE_TICK0 = '{phi_0: 1'b0, q3: 1'b1, pras_n: 1'b1,
                                         pcas_n: 1'b1, ax: 1'b1};

    function automatic logic in_window(input tick_t t, input tick_t first,
                                       input tick_t last);
        return (t >= first) && (t <= last);
    endfunction

endpackage

// File: rtl/apple_iie_timing_decode.sv
// Pure combinational strobe decode: (tick, long_cycle) -> phi0/Q3/RAS/CAS/AX.
module apple_iie_timing_decode
    import apple_iie_timing_pkg::*;
#(
    parameter tick_t LONG_LAST = TICK_LONG_LAST
) (
    input  tick_t   tick_i,
    input  logic    long_cycle_i,
    output strobe_t strobe_o
);

    tick_t last;

    always_comb begin
        strobe_o = STROBE_TICK0;
        last     = long_cycle_i ? LONG_LAST : TICK_NORMAL_LAST;

        strobe_o.phi_0  = in_window(tick_i, PHI0_FIRST, last);
        strobe_o.q3     = in_window(tick_i, Q3_A_FIRST, Q3_A_LAST)
                       || in_window(tick_i, Q3_B_FIRST, Q3_B_LAST);
        strobe_o.pras_n = !(in_window(tick_i, RAS_A_FIRST, RAS_A_LAST)
                       ||   in_window(tick_i, RAS_B_FIRST, last));
        strobe_o.pcas_n = !(in_window(tick_i, CAS_A_FIRST, CAS_A_LAST)
                       ||   in_window(tick_i, CAS_B_FIRST, last));
        strobe_o.ax     = in_window(tick_i, AX_A_FIRST, AX_A_LAST)
                       || in_window(tick_i, AX_B_FIRST, AX_B_LAST);
    end

endmodule

// File: rtl/apple_iie_timing_generator.sv
// Apple IIe master timing generator: 14M tick/line/frame counters with
// registered strobes. Define TIMING_PAL_EN for the 312-line PAL frame.
module apple_iie_timing_generator
    import apple_iie_timing_pkg::*;
#(
    parameter int H_CYCLES     = H_CYCLES_DEF,
    parameter int LONG_EXTRA   = LONG_EXTRA_DEF,
    parameter int V_LINES_NTSC = V_LINES_NTSC_DEF,
    parameter int V_LINES_PAL  = V_LINES_PAL_DEF
) (
    input  logic       clk_14m,
    input  logic       reset,
    output logic       clk_phi_0,
    output logic       clk_phi_1,
    output logic       clk_q3,
    output logic       clk_7m,
    output logic       clk_color_ref,
    output logic       pras_n,
    output logic       pcas_n,
    output logic       ax,
    output logic       phi0_fall,
    output logic [6:0] h_count,
    output logic [8:0] v_count,
    output logic       line_start,
    output logic       frame_start
);

`ifdef TIMING_PAL_EN
    localparam bit PAL_BUILD = 1'b1;
`else
    localparam bit PAL_BUILD = 1'b0;
`endif
    localparam int         V_LINES   = PAL_BUILD ? V_LINES_PAL : V_LINES_NTSC;
    localparam logic [6:0] H_LAST    = 7'(H_CYCLES - 1);
    localparam logic [8:0] V_LAST    = 9'(V_LINES - 1);
    localparam tick_t      LONG_LAST = 4'(int'(TICK_NORMAL_LAST) + LONG_EXTRA);

    tick_t      tick_q, tick_d;
    logic [6:0] h_q, h_d;
    logic [8:0] v_q, v_d;
    logic [1:0] div_q;
    logic       long_cur, long_d;
    strobe_t    strobe_d, strobe_q;
    logic       phi1_q, fall_q, line_q, frame_q;

    assign long_cur = (h_q == H_LAST);

    always_comb begin
        tick_d = tick_q + 4'd1;
        h_d    = h_q;
        v_d    = v_q;
        if (tick_q == (long_cur ? LONG_LAST : TICK_NORMAL_LAST)) begin
            tick_d = '0;
            if (long_cur) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
            end else begin
                h_d = h_q + 7'd1;
            end
        end
    end

    assign long_d = (h_d == H_LAST);

    // Decode the upcoming tick so the registered strobes line up with it.
    apple_iie_timing_decode #(
        .LONG_LAST(LONG_LAST)
    ) u_decode (
        .tick_i      (tick_d),
        .long_cycle_i(long_d),
        .strobe_o    (strobe_d)
    );

    always_ff @(posedge clk_14m) begin
        if (reset) begin
            tick_q   <= '0;
            h_q      <= '0;
            v_q      <= '0;
            div_q    <= '0;
            strobe_q <= STROBE_TICK0;
            phi1_q   <= 1'b1;
            fall_q   <= 1'b1;
            line_q   <= 1'b1;
            frame_q  <= 1'b1;
        end else begin
            tick_q   <= tick_d;
            h_q      <= h_d;
            v_q      <= v_d;
            // Free-running: the 912-tick line is a multiple of 4, so the
            // colour phase stays line-locked without any resync.
            div_q    <= div_q + 2'd1;
            strobe_q <= strobe_d;
            phi1_q   <= ~strobe_d.phi_0;
            fall_q   <= (tick_d == 4'd0);
            line_q   <= (tick_d == 4'd0) && (h_d == 7'd0);
            frame_q  <= (tick_d == 4'd0) && (h_d == 7'd0) && (v_d == 9'd0);
        end
    end

    assign clk_phi_0     = strobe_q.phi_0;
    assign clk_phi_1     = phi1_q;
    assign clk_q3        = strobe_q.q3;
    assign pras_n        = strobe_q.pras_n;
    assign pcas_n        = strobe_q.pcas_n;
    assign ax            = strobe_q.ax;
    assign clk_7m        = div_q[0];
    assign clk_color_ref = div_q[1];
    assign phi0_fall     = fall_q;
    assign line_start    = line_q;
    assign frame_start   = frame_q;
    assign h_count       = h_q;
    assign v_count       = v_q;

endmodule

// File: tb/tb_apple_iie_timing_generator.sv
// Directed bench for apple_iie_timing_generator; frame length shortened via
// the V_LINES parameters so frame wrap fits in a short run.
module tb_apple_iie_timing_generator;

    localparam int TB_V_NTSC = 4;
    localparam int TB_V_PAL  = 5;
`ifdef TIMING_PAL_EN
    localparam int V_LINES_TB = TB_V_PAL;
`else
    localparam int V_LINES_TB = TB_V_NTSC;
`endif
    localparam int LINE_TICKS  = 912;
    localparam int FRAME_TICKS = V_LINES_TB * LINE_TICKS;

    // Bit n = value during tick n.
    localparam logic [15:0] PHI0_NORM = 16'h3F80;
    localparam logic [15:0] PHI0_LONG = 16'hFF80;
    localparam logic [15:0] Q3_MASK   = 16'h078F;
    localparam logic [15:0] PRAS_HI   = 16'h0183;
    localparam logic [15:0] PCAS_HI   = 16'h078F;
    localparam logic [15:0] AX_MASK   = 16'h0387;

    logic       clk_14m = 1'b0;
    logic       reset   = 1'b1;
    logic       clk_phi_0, clk_phi_1, clk_q3, clk_7m, clk_color_ref;
    logic       pras_n, pcas_n, ax, phi0_fall, line_start, frame_start;
    logic [6:0] h_count;
    logic [8:0] v_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_tick;
    logic [6:0] m_h;
    logic [8:0] m_v;
    logic [1:0] m_div;

    int          n, ticks, phi_hi, q3_hi, rises;
    logic [15:0] rf, cf;
    logic        c0, s0, prev;

    apple_iie_timing_generator #(
        .V_LINES_NTSC(TB_V_NTSC),
        .V_LINES_PAL (TB_V_PAL)
    ) dut (
        .clk_14m      (clk_14m),
        .reset        (reset),
        .clk_phi_0    (clk_phi_0),
        .clk_phi_1    (clk_phi_1),
        .clk_q3       (clk_q3),
        .clk_7m       (clk_7m),
        .clk_color_ref(clk_color_ref),
        .pras_n       (pras_n),
        .pcas_n       (pcas_n),
        .ax           (ax),
        .phi0_fall    (phi0_fall),
        .h_count      (h_count),
        .v_count      (v_count),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    always #5 clk_14m = ~clk_14m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] pm, qm, rm, cm, am;
        logic        p0;
        logic [26:0] exp_v, obs_v;
        pm = (m_h == 7'd64) ? PHI0_LONG : PHI0_NORM;
        qm = Q3_MASK;
        rm = PRAS_HI;
        cm = PCAS_HI;
        am = AX_MASK;
        p0 = pm[m_tick];
        exp_v = {p0, ~p0, qm[m_tick], m_div[0], m_div[1], rm[m_tick], cm[m_tick],
                 am[m_tick], (m_tick == 4'd0), (m_tick == 4'd0 && m_h == 7'd0),
                 (m_tick == 4'd0 && m_h == 7'd0 && m_v == 9'd0), m_h, m_v};
        obs_v = {clk_phi_0, clk_phi_1, clk_q3, clk_7m, clk_color_ref, pras_n, pcas_n,
                 ax, phi0_fall, line_start, frame_start, h_count, v_count};
        chk("cycle_vec", 32'(obs_v), 32'(exp_v));
        chk("ras_cas_ax", 32'(ax & ~pras_n & ~pcas_n), 32'd0);
    endtask

    task automatic step();
        @(posedge clk_14m);
        if (reset) begin
            m_tick = '0;
            m_h    = '0;
            m_v    = '0;
            m_div  = '0;
        end else begin
            m_div = m_div + 2'd1;
            if ((m_h != 7'd64 && m_tick == 4'd13) || (m_h == 7'd64 && m_tick == 4'd15)) begin
                m_tick = '0;
                if (m_h == 7'd64) begin
                    m_h = '0;
                    m_v = (m_v == 9'(V_LINES_TB - 1)) ? 9'd0 : m_v + 9'd1;
                end else begin
                    m_h = m_h + 7'd1;
                end
            end else begin
                m_tick = m_tick + 4'd1;
            end
        end
        @(negedge clk_14m);
        check_all();
    endtask

    // Starts at a tick-0 sample; ends at the next tick-0 sample.
    task automatic measure_cycle(output int t_cnt, output int p_hi, output int q_hi,
                                 output logic [15:0] r_f, output logic [15:0] c_f);
        logic pr, pc;
        t_cnt = 0;
        p_hi  = 0;
        q_hi  = 0;
        r_f   = '0;
        c_f   = '0;
        pr    = pras_n;
        pc    = pcas_n;
        do begin
            if (pr && !pras_n) r_f[t_cnt[3:0]] = 1'b1;
            if (pc && !pcas_n) c_f[t_cnt[3:0]] = 1'b1;
            if (clk_phi_0) p_hi++;
            if (clk_q3) q_hi++;
            pr = pras_n;
            pc = pcas_n;
            step();
            t_cnt++;
        end while (!phi0_fall && t_cnt < 20);
    endtask

    initial begin
        // Reset held for 5 ticks
        reset = 1'b1;
        repeat (5) begin
            step();
            chk("rst_vec", 32'({clk_phi_0, clk_phi_1, clk_q3, pras_n, pcas_n, ax, clk_7m,
                                clk_color_ref, phi0_fall, line_start, frame_start}),
                32'(11'b01111100111));
        end

        reset = 1'b0;
        step();
        chk("first_q3", 32'(clk_q3), 32'd1);
        chk("first_ax", 32'(ax), 32'd1);
        n = 1;
        while (!clk_phi_0 && n < 20) begin
            step();
            n++;
        end
        chk("phi0_rise_delay", 32'(n), 32'd7);

        // One normal cycle
        n = 0;
        while (!phi0_fall && n < 20) begin
            step();
            n++;
        end
        measure_cycle(ticks, phi_hi, q3_hi, rf, cf);
        chk("norm_ticks", 32'(ticks), 32'd14);
        chk("norm_phi0_hi", 32'(phi_hi), 32'd7);
        chk("norm_q3_hi", 32'(q3_hi), 32'd8);
        chk("norm_ras_fall", 32'(rf), 32'h0204);
        chk("norm_cas_fall", 32'(cf), 32'h0810);

        // Long cycle at h_count 64
        n = 0;
        while (!(h_count == 7'd64 && phi0_fall) && n < 1000) begin
            step();
            n++;
        end
        chk("reach_long", 32'(n < 1000), 32'd1);
        measure_cycle(ticks, phi_hi, q3_hi, rf, cf);
        chk("long_ticks", 32'(ticks), 32'd16);
        chk("long_phi0_hi", 32'(phi_hi), 32'd9);
        chk("long_q3_hi", 32'(q3_hi), 32'd8);
        chk("long_ras_fall", 32'(rf), 32'h0204);
        chk("long_cas_fall", 32'(cf), 32'h0810);
        chk("after_long_h", 32'(h_count), 32'd0);
        chk("after_long_ls", 32'(line_start), 32'd1);
        step();
        chk("ls_one_tick", 32'(line_start), 32'd0);

        // Colour reference over one line
        n = 0;
        while (!line_start && n < 1000) begin
            step();
            n++;
        end
        chk("reach_line", 32'(n < 1000), 32'd1);
        c0    = clk_color_ref;
        s0    = clk_7m;
        prev  = clk_color_ref;
        rises = 0;
        repeat (LINE_TICKS) begin
            step();
            if (!prev && clk_color_ref) rises++;
            prev = clk_color_ref;
        end
        chk("color_line_ls", 32'(line_start), 32'd1);
        chk("color_periods", 32'(rises), 32'd228);
        chk("color_phase", 32'({clk_color_ref, clk_7m}), 32'({c0, s0}));

        // Frame period
        n = 0;
        while (!frame_start && n < FRAME_TICKS + 20) begin
            step();
            n++;
        end
        chk("reach_frame", 32'(n < FRAME_TICKS + 20), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < FRAME_TICKS + 20);
        chk("frame_ticks", 32'(n), 32'(FRAME_TICKS));
        chk("frame_v", 32'(v_count), 32'd0);

        // Reset at tick 12 of the long cycle, on a non-zero line
        n = 0;
        while (!(h_count == 7'd64 && phi0_fall && v_count != 9'd0) && n < 2000) begin
            step();
            n++;
        end
        chk("reach_long2", 32'(n < 2000), 32'd1);
        repeat (12) step();
        chk("t12_pcas", 32'(pcas_n), 32'd0);
        chk("t12_phi0", 32'(clk_phi_0), 32'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_h", 32'(h_count), 32'd0);
        chk("rst_mid_v", 32'(v_count), 32'd0);
        chk("rst_mid_fs", 32'(frame_start), 32'd1);
        reset = 1'b0;
        measure_cycle(ticks, phi_hi, q3_hi, rf, cf);
        chk("post_rst_ticks", 32'(ticks), 32'd14);
        chk("post_rst_phi0_hi", 32'(phi_hi), 32'd7);
        chk("post_rst_h", 32'(h_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple_iie_timing_generator.md
Name: apple_iie_timing_generator

Overview:
Master timing generator driving the memory management unit. Divides the 14.318 MHz master clock into clk_phi_0, clk_phi_1, clk_q3, clk_7m, the colour reference, pras_n, pcas_n and the ax row/column mux select. Runs the 65-cycle horizontal counter with the stretched ("long") last cycle of each line, and a vertical line counter. All outputs are registered and feed the MMU, IOU and video stages directly.

Parameters:
H_CYCLES, 65, CPU cycles per scan line; the last cycle, index H_CYCLES-1, is long.
LONG_EXTRA, 2, extra 14M ticks appended to phi0-high in the long cycle.
V_LINES_NTSC, 262, lines per frame when TIMING_PAL_EN is undefined.
V_LINES_PAL, 312, lines per frame when TIMING_PAL_EN is defined.

Ports:
clk_14m  input  1  14.318 MHz master clock; only clock in the block
reset  input  1  synchronous, active-high
clk_phi_0  output  1  CPU phase 0 (high = CPU half-cycle)
clk_phi_1  output  1  inverse of clk_phi_0
clk_q3  output  1  asymmetric Q3 strobe
clk_7m  output  1  14M divided by 2
clk_color_ref  output  1  14M divided by 4, free-running
pras_n  output  1  DRAM row strobe, active low
pcas_n  output  1  DRAM column strobe, active low
ax  output  1  1 = row address phase, 0 = column phase
phi0_fall  output  1  one-tick pulse on the tick after phi0 drops (tick 0)
h_count  output  7  CPU cycle within line, 0..H_CYCLES-1
v_count  output  9  line within frame
line_start  output  1  one-tick pulse at tick 0 of h_count 0
frame_start  output  1  one-tick pulse at tick 0 of h_count 0, v_count 0

Behaviour:
- Interface: single clock clk_14m; reset synchronous, active-high. All state changes occur only on rising clk_14m.
- State:
  - tick counter, 4 bits: 0..13 in a normal cycle, 0..15 in the long cycle.
  - h_count and v_count.
  - clk_7m / clk_color_ref divider, 2 bits, independent of tick.
- Outputs are flops loaded from the next-state decode. During tick n every output equals the table value for n; there is zero decode latency.
- Decode table, by tick (long-cycle values in brackets):
  - clk_phi_0 = 1 for ticks 7..13 [7..15], else 0. clk_phi_1 = ~clk_phi_0.
  - clk_q3 = 1 for ticks 0..3 and 7..10, else 0.
  - pras_n = 0 for ticks 2..6 and 9..13 [9..15], else 1.
  - ax = 1 for ticks 0..2 and 7..9, else 0.
  - pcas_n = 0 for ticks 4..6 and 11..13 [11..15], else 1.
- Counter progression:
  - tick wraps to 0 after 13, or after 15 when h_count==H_CYCLES-1.
  - h_count increments on that wrap and wraps H_CYCLES-1 -> 0.
  - v_count increments when h_count wraps, and wraps at V_LINES-1 -> 0.
- Colour reference: the divider never resets except by reset. A line is 65*14+2 = 912 ticks, a multiple of 4, so colour phase is line-locked. The long cycle must not pause the divider.
- Pulses:
  - phi0_fall is high at tick 0 of every cycle.
  - line_start is phi0_fall AND h_count==0.
  - frame_start is line_start AND v_count==0.
- Reset, including mid-cycle or mid-long-cycle:
  - Next tick: tick=0, h_count=0, v_count=0, divider=0.
  - Outputs take tick-0 values: clk_phi_0=0, clk_phi_1=1, clk_q3=1, pras_n=1, pcas_n=1, ax=1, clk_7m=0, clk_color_ref=0, phi0_fall=1, line_start=1, frame_start=1.
  - These values are held while reset stays high.
  - The first tick after reset deasserts is tick 1.
- pras_n and pcas_n are never both low while ax=1; the bench asserts this.

Optional Feature:
- TIMING_PAL_EN defined: frame length is V_LINES_PAL (312), v_count wraps 311 -> 0.
- TIMING_PAL_EN undefined: frame length is V_LINES_NTSC (262), v_count wraps 261 -> 0.
- Nothing else changes.

Decomposition:
- Shared package apple_iie_timing_pkg holds:
  - tick constants TICK_NORMAL_LAST=13 and TICK_LONG_LAST=15;
  - the decode boundary constants;
  - the H_CYCLES / V_LINES defaults;
  - a typedef for the tick index.
- One sub-module is natural: apple_iie_timing_decode, a pure function of (tick, long_cycle) producing the strobe vector. It is reused by the video-stage model.

Test Plan:
- Reset held for 5 ticks, then released -> during reset outputs show the tick-0 values; the first post-reset tick has clk_q3=1 and ax=1; clk_phi_0 first rises 7 ticks after the last reset tick.
- Free-run over one normal cycle -> clk_phi_0 high for exactly 7 ticks and clk_q3 high for 4+4 ticks; pras_n falls at ticks 2 and 9, pcas_n falls at ticks 4 and 11.
- h_count==64 -> cycle lasts 16 ticks with clk_phi_0 high for 9 ticks; then h_count=0 and line_start=1 for exactly one tick.
- 912 ticks starting at line_start -> clk_color_ref completes exactly 228 periods and is in the same phase at both line_starts.
- Full frame, NTSC build -> frame_start recurs every 262*912 ticks; PAL build (TIMING_PAL_EN) -> every 312*912 ticks.
- Reset asserted at tick 12 of the long cycle -> next tick is tick 0 with h_count=0 and v_count=0; no truncated 16-tick cycle follows.
